timer_tick_scheduler: RTL

- Avalon-MM master sequencer that owns the system interval timer's 16-bit slave port (addresses 0 status, 1 control, 2 period_l, 3 period_h).
- Programs the timer period, starts it in continuous interrupt mode, services each timeout interrupt by clearing status, and fans each timeout out as divided tick pulses to NUM_CH consumer channels (NN accelerator layer sequencer, sampling logic).
- Sits between the timer and the accelerator control logic, replacing software ISR servicing.

---
 rtl/timer_tick_scheduler.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/timer_tick_scheduler.sv
// Avalon-MM sequencer for the interval timer: programs it, services timeouts and fans them out as per-channel divided ticks.
// Optional build macro TICK_WATCHDOG_EN adds a sticky missing-timeout watchdog on err_wdog.
module timer_tick_scheduler #(
    parameter int NUM_CH     = 4,
    parameter int DIV_W      = 8,
    parameter int MIN_PERIOD = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cfg_start,
    input  logic                    cfg_stop,
    input  logic [31:0]             cfg_period,
    input  logic [NUM_CH-1:0]       cfg_ch_en,
    input  logic [NUM_CH*DIV_W-1:0] cfg_div,
    output logic [2:0]              tmr_address,
    output logic                    tmr_chipselect,
    output logic                    tmr_write_n,
    output logic [15:0]             tmr_writedata,
    input  logic                    tmr_irq,
    output logic [NUM_CH-1:0]       ch_tick,
    output logic                    busy,
    output logic [15:0]             tick_count,
    output logic                    err_wdog
);

    // state    | meaning
    // IDLE     | timer not owned, waiting for cfg_start
    // WR_PL    | writing period_l
    // WR_PH    | writing period_h
    // WR_CTRL  | writing START|CONT|ITO
    // RUN      | waiting for timeout or stop
    // ACK      | clearing timer status
    // TICK     | advancing channel dividers
    // WR_STOP  | writing STOP
    typedef enum logic [2:0] {
        S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTRL, S_RUN, S_ACK, S_TICK, S_WR_STOP
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_accept;
    logic [31:0]        w_period_clamp;
    logic [31:0]        r_period;
    logic [NUM_CH-1:0]  r_ch_en;
    logic [DIV_W-1:0]   r_div [NUM_CH];
    logic [DIV_W-1:0]   r_cnt [NUM_CH];
    logic               r_stop_pend;

    assign w_accept       = (r_state == S_IDLE) && cfg_start && !cfg_stop;
    assign w_period_clamp = (cfg_period < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : cfg_period;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next = S_WR_PL;
            S_WR_PL:   w_next = S_WR_PH;
            S_WR_PH:   w_next = S_WR_CTRL;
            S_WR_CTRL: w_next = S_RUN;
            S_RUN: begin
                if (r_stop_pend || cfg_stop) w_next = S_WR_STOP;
                else if (tmr_irq)            w_next = S_ACK;
            end
            S_ACK:     w_next = S_TICK;
            S_TICK:    w_next = S_RUN;
            S_WR_STOP: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_period    <= '0;
            r_ch_en     <= '0;
            r_stop_pend <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) r_div[i] <= '0;
        end else if (w_accept) begin
            r_period    <= w_period_clamp;
            r_ch_en     <= cfg_ch_en;
            r_stop_pend <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) r_div[i] <= cfg_div[i*DIV_W +: DIV_W];
        end else if (cfg_stop && r_state != S_IDLE && r_state != S_RUN) begin
            r_stop_pend <= 1'b1;
        end
    end

    // Bus outputs are decoded from the next state so each write appears in its own state cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmr_address    <= 3'd0;
            tmr_chipselect <= 1'b0;
            tmr_write_n    <= 1'b1;
            tmr_writedata  <= 16'h0000;
            busy           <= 1'b0;
            tick_count     <= 16'h0000;
        end else begin
            tmr_chipselect <= 1'b0;
            tmr_write_n    <= 1'b1;
            busy           <= (w_next != S_IDLE);
            case (w_next)
                S_WR_PL: begin
                    tmr_address <= 3'd2; tmr_writedata <= w_period_clamp[15:0];
                    tmr_chipselect <= 1'b1; tmr_write_n <= 1'b0;
                end
                S_WR_PH: begin
                    tmr_address <= 3'd3; tmr_writedata <= r_period[31:16];
                    tmr_chipselect <= 1'b1; tmr_write_n <= 1'b0;
                end
                S_WR_CTRL: begin
                    tmr_address <= 3'd1; tmr_writedata <= 16'h0007;
                    tmr_chipselect <= 1'b1; tmr_write_n <= 1'b0;
                end
                S_ACK: begin
                    tmr_address <= 3'd0; tmr_writedata <= 16'h0000;
                    tmr_chipselect <= 1'b1; tmr_write_n <= 1'b0;
                end
                S_WR_STOP: begin
                    tmr_address <= 3'd1; tmr_writedata <= 16'h0008;
                    tmr_chipselect <= 1'b1; tmr_write_n <= 1'b0;
                end
                default: ;
            endcase
            if (w_accept)               tick_count <= 16'h0000;
            else if (r_state == S_ACK)  tick_count <= tick_count + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch_tick <= '0;
            for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
        end else begin
            ch_tick <= '0;
            if (w_accept) begin
                for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= cfg_div[i*DIV_W +: DIV_W];
            end else if (r_state == S_ACK) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (r_ch_en[i]) begin
                        if (r_cnt[i] == '0) begin
                            ch_tick[i] <= 1'b1;
                            r_cnt[i]   <= r_div[i];
                        end else begin
                            r_cnt[i] <= r_cnt[i] - 1'b1;
                        end
                    end
                end
            end
        end
    end

`ifdef TICK_WATCHDOG_EN
    logic [32:0] r_wdog;
    logic        r_err;
    logic [32:0] w_limit;

    // Compare with >= so the flag is visible on the first cycle the count exceeds period+16.
    assign w_limit = {1'b0, r_period} + 33'd16;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_accept)                                   r_err <= 1'b0;
            else if (r_state == S_RUN && r_wdog >= w_limit) r_err <= 1'b1;
            if (w_next == S_RUN && (r_state == S_WR_CTRL || r_state == S_TICK))
                r_wdog <= '0;
            else if (r_state == S_RUN || r_state == S_ACK || r_state == S_TICK)
                r_wdog <= r_wdog + 33'd1;
        end
    end

    assign err_wdog = r_err;
`else
    assign err_wdog = 1'b0;
`endif

endmodule
